// File: rtl/updown_pkg.sv
// Shared types for the up/down sweep controller: FSM states,
// counter mode encoding and default widths.
package updown_pkg;

   localparam int CNT_W_DEF   = 8;
   localparam int SWEEP_W_DEF = 8;
   localparam int DWELL_W_DEF = 4;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR     = 3'd1,
      UP        = 3'd2,
      DWELL_TOP = 3'd3,
      DOWN      = 3'd4,
      DWELL_BOT = 3'd5,
      DONE      = 3'd6
   } state_e;

   function automatic logic is_busy(state_e s);
      return (s == CLEAR) || (s == UP) ||
             (s == DWELL_TOP) || (s == DOWN) ||
             (s == DWELL_BOT);
   endfunction

   // Mode is set on entry to a state, so a dwell already
   // carries the direction of the phase that follows it.
   function automatic logic mode_of(state_e s);
      return ((s == DWELL_TOP) || (s == DOWN)) ?
             MODE_DOWN : MODE_UP;
   endfunction

endpackage

// File: rtl/updown_dwell_timer.sv
// Loadable down-counter that flags the last cycle of a dwell;
// shared by the top and bottom turnaround dwells.
module updown_dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] len_i,
   input  logic         run_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = len_i - W'(1);
      end else if (run_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for the 8-bit up/down counter.
// Optional UPDOWN_SWEEP_LIMIT_EN adds a programmable UP turnaround.
module updown_sweep_ctrl
   import updown_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int SWEEP_W = SWEEP_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [SWEEP_W-1:0] cfg_sweeps,
   input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef UPDOWN_SWEEP_LIMIT_EN
   input  logic [CNT_W-1:0]   cfg_limit,
`endif
   input  logic [CNT_W-1:0]   cnt_count,
   input  logic               cnt_tc,
   output logic               cnt_enable,
   output logic               cnt_mode,
   output logic               cnt_clear,
   output logic               busy,
   output logic               done,
   output logic [SWEEP_W-1:0] sweep_idx
);

   state_e             state_q;
   state_e             state_d;
   logic [SWEEP_W-1:0] sweeps_q;
   logic [SWEEP_W-1:0] sweeps_d;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_d;
   logic [SWEEP_W-1:0] idx_q;
   logic [SWEEP_W-1:0] idx_d;
   logic               mode_q;
   logic               clear_q;
   logic               busy_q;
   logic               done_q;
   logic               dwell_load;
   logic               dwell_run;
   logic               dwell_exp;
   logic               up_turn;
   logic               last_sweep;

`ifdef UPDOWN_SWEEP_LIMIT_EN
   logic [CNT_W-1:0]   limit_q;
   logic [CNT_W-1:0]   limit_d;

   assign up_turn = cnt_tc || (cnt_count == limit_q);
`else
   logic               unused_cnt;

   assign unused_cnt = ^cnt_count;
   assign up_turn    = cnt_tc;
`endif

   assign last_sweep = (sweeps_q != '0) &&
                       ((idx_q + SWEEP_W'(1)) == sweeps_q);

   assign dwell_run = (state_q == DWELL_TOP) ||
                      (state_q == DWELL_BOT);

   updown_dwell_timer #(
      .W (DWELL_W)
   ) u_dwell (
      .clk      (clk),
      .rst      (reset),
      .load_i   (dwell_load),
      .len_i    (dwell_q),
      .run_i    (dwell_run),
      .expire_o (dwell_exp)
   );

   always_comb begin
      state_d    = state_q;
      sweeps_d   = sweeps_q;
      dwell_d    = dwell_q;
      idx_d      = idx_q;
      dwell_load = 1'b0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
      limit_d    = limit_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d  = CLEAR;
               sweeps_d = cfg_sweeps;
               dwell_d  = cfg_dwell;
               idx_d    = '0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
               limit_d  = cfg_limit;
`endif
            end
         end
         CLEAR: begin
            state_d = UP;
         end
         UP: begin
            if (up_turn) begin
               if (dwell_q != '0) begin
                  state_d    = DWELL_TOP;
                  dwell_load = 1'b1;
               end else begin
                  state_d = DOWN;
               end
            end
         end
         DWELL_TOP: begin
            if (dwell_exp) begin
               state_d = DOWN;
            end
         end
         DOWN: begin
            if (cnt_tc) begin
               idx_d = idx_q + SWEEP_W'(1);
               if (last_sweep) begin
                  state_d = DONE;
               end else if (dwell_q != '0) begin
                  state_d    = DWELL_BOT;
                  dwell_load = 1'b1;
               end else begin
                  state_d = UP;
               end
            end
         end
         DWELL_BOT: begin
            if (dwell_exp) begin
               state_d = UP;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Abort leaves the sweep index where the run stopped.
      if (stop && is_busy(state_q)) begin
         state_d    = IDLE;
         idx_d      = idx_q;
         dwell_load = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sweeps_q <= '0;
         dwell_q  <= '0;
         idx_q    <= '0;
         mode_q   <= MODE_UP;
         clear_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sweeps_q <= sweeps_d;
         dwell_q  <= dwell_d;
         idx_q    <= idx_d;
         mode_q   <= mode_of(state_d);
         clear_q  <= (state_d == CLEAR);
         busy_q   <= is_busy(state_d);
         done_q   <= (state_d == DONE);
      end
   end

`ifdef UPDOWN_SWEEP_LIMIT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         limit_q <= '0;
      end else begin
         limit_q <= limit_d;
      end
   end
`endif

   // Gating on tc and stop here keeps the counter from wrapping
   // and freezes it in the very cycle stop arrives.
   assign cnt_enable = (((state_q == UP) && !up_turn) ||
                        ((state_q == DOWN) && !cnt_tc)) &&
                       !stop;

   assign cnt_mode  = mode_q;
   assign cnt_clear = clear_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sweep_idx = idx_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl with a behavioural 8-bit counter.
// Build with +define+UPDOWN_SWEEP_LIMIT_EN to cover the limit.
module tb_updown_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic [7:0] cfg_sweeps;
   logic [3:0] cfg_dwell;
`ifdef UPDOWN_SWEEP_LIMIT_EN
   logic [7:0] cfg_limit;
`endif
   logic [7:0] cnt_count = 8'd0;
   logic       cnt_tc;
   logic       cnt_enable;
   logic       cnt_mode;
   logic       cnt_clear;
   logic       busy;
   logic       done;
   logic [7:0] sweep_idx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int st_busy, st_clear, st_clear_at, st_done, st_done_at;
   int st_wrap, st_peak, st_top, st_bot;
   int peak;
   int prev_cnt;

   always #5 clk = ~clk;

   updown_sweep_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .cfg_sweeps (cfg_sweeps),
      .cfg_dwell  (cfg_dwell),
`ifdef UPDOWN_SWEEP_LIMIT_EN
      .cfg_limit  (cfg_limit),
`endif
      .cnt_count  (cnt_count),
      .cnt_tc     (cnt_tc),
      .cnt_enable (cnt_enable),
      .cnt_mode   (cnt_mode),
      .cnt_clear  (cnt_clear),
      .busy       (busy),
      .done       (done),
      .sweep_idx  (sweep_idx)
   );

   // Behavioural model of the team's up/down counter.
   assign cnt_tc = cnt_mode ? (cnt_count == 8'd0)
                            : (cnt_count == 8'hFF);

   always @(posedge clk) begin
      if (cnt_clear)
         cnt_count <= 8'd0;
      else if (cnt_enable)
         cnt_count <= cnt_mode ? cnt_count - 8'd1
                               : cnt_count + 8'd1;
   end

   task automatic chk(input string tag, input int obs,
                      input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      st_busy = 0; st_clear = 0; st_clear_at = -1;
      st_done = 0; st_done_at = -1; st_wrap = 0;
      st_peak = 0; st_top = 0; st_bot = 0;
      prev_cnt = int'(cnt_count);
   endtask

   // One clock; observations happen at the falling edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (busy) st_busy++;
      if (cnt_clear) begin
         st_clear++;
         st_clear_at = cyc;
      end
      if (done) begin
         st_done++;
         st_done_at = cyc;
      end
      if (cnt_enable && !cnt_mode && cnt_count == 8'hFF)
         st_wrap++;
      if (cnt_enable && cnt_mode && cnt_count == 8'd0)
         st_wrap++;
      if (busy && int'(cnt_count) == peak &&
          prev_cnt != peak)
         st_peak++;
      if (busy && int'(cnt_count) == peak && cnt_mode &&
          !cnt_enable)
         st_top++;
      if (busy && !cnt_clear && cnt_count == 8'd0 &&
          !cnt_mode && !cnt_enable)
         st_bot++;
      prev_cnt = int'(cnt_count);
   endtask

   // Full programmed run; expectations from sweep arithmetic.
   task automatic run_and_check(input int s, input int d,
                                input int lim);
      int t0, k, up_len, exp_busy;
      cfg_sweeps = 8'(s);
      cfg_dwell  = 4'(d);
`ifdef UPDOWN_SWEEP_LIMIT_EN
      cfg_limit  = 8'(lim);
`endif
      peak = lim;
      clr_stats();
      t0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_sweeps = 8'($urandom);
      cfg_dwell  = 4'($urandom);
`ifdef UPDOWN_SWEEP_LIMIT_EN
      cfg_limit  = 8'($urandom);
`endif
      k = 0;
      while (st_done == 0 && k < 6000) begin
         step();
         k++;
      end
      step();
      step();
      up_len   = lim + 1;
      exp_busy = 1 + s * 2 * up_len + d * (2 * s - 1);
      chk("clear_at", st_clear_at - t0, 1);
      chk("clear_pulses", st_clear, 1);
      chk("busy_cycles", st_busy, exp_busy);
      chk("done_at", st_done_at - t0, exp_busy + 1);
      chk("done_pulses", st_done, 1);
      chk("peaks", st_peak, s);
      chk("no_wrap", st_wrap, 0);
      chk("top_dwell", st_top, d * s);
      chk("bot_dwell", st_bot, d * (s - 1));
      chk("sweep_idx", int'(sweep_idx), s);
      chk("idle_busy", int'(busy), 0);
      chk("idle_enable", int'(cnt_enable), 0);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      cfg_sweeps = 8'd0;
      cfg_dwell  = 4'd0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
      cfg_limit  = 8'd255;
`endif
      peak = 255;
      clr_stats();
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_enable", int'(cnt_enable), 0);
      chk("rst_mode", int'(cnt_mode), 0);
      chk("rst_clear", int'(cnt_clear), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_idx", int'(sweep_idx), 0);
      step();
      step();
      reset = 1'b0;
      step();

      run_and_check(2, 0, 255);
      run_and_check(1, 5, 255);
      for (int i = 0; i < 3; i++)
         run_and_check($urandom_range(1, 2),
                       $urandom_range(0, 15), 255);

      // Endless run, start while busy, then stop at 100.
      cfg_sweeps = 8'd0;
      cfg_dwell  = 4'd0;
`ifdef UPDOWN_SWEEP_LIMIT_EN
      cfg_limit  = 8'd255;
`endif
      peak = 255;
      clr_stats();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (sweep_idx != 8'd3 && k < 2000) begin
         step();
         k++;
      end
      chk("inf_idx3", int'(sweep_idx), 3);
      chk("inf_no_done", st_done, 0);
      chk("inf_one_clear", st_clear, 1);
      chk("inf_no_wrap", st_wrap, 0);
      k = 0;
      while (!(busy && !cnt_mode && cnt_count == 8'd100) &&
             k < 400) begin
         step();
         k++;
      end
      chk("stop_at100", int'(cnt_count), 100);
      stop = 1'b1;
      #1;
      chk("stop_enable", int'(cnt_enable), 0);
      step();
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_count", int'(cnt_count), 100);
      chk("stop_idx", int'(sweep_idx), 3);
      step();
      chk("stop_frozen", int'(cnt_count), 100);
      chk("stop_no_done", st_done, 0);

      // stop beats start in IDLE.
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      step();
      chk("ss_busy", int'(busy), 0);
      chk("ss_clear", st_clear, 1);

      // Asynchronous reset in the middle of a run.
      cfg_sweeps = 8'd1;
      cfg_dwell  = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (299) step();
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_mode", int'(cnt_mode), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_enable", int'(cnt_enable), 0);
      chk("arst_mode", int'(cnt_mode), 0);
      chk("arst_clear", int'(cnt_clear), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_idx", int'(sweep_idx), 0);
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("post_rst_busy", int'(busy), 0);
      run_and_check(1, 3, 255);

`ifdef UPDOWN_SWEEP_LIMIT_EN
      run_and_check(1, 0, 10);
      run_and_check(2, $urandom_range(1, 15),
                    $urandom_range(1, 254));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer for the team's 8-bit up/down counter (ports clk, enable, reset, mode, count, tc).
- Drives the counter's enable, mode and reset pins so it runs a programmed number of full sweeps: 0 up to max, then max down to 0.
- Holds a programmable dwell at each turnaround.
- Stops on tc without ever wrapping the counter.
- Sits between a start/stop control interface and one counter instance.

Parameters:
CNT_W, 8, counter width; max value is 2^CNT_W-1.
SWEEP_W, 8, width of the sweep-count config and the sweep index.
DWELL_W, 4, width of the dwell-length config.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
stop  input  1  abort request; honoured in any busy state
cfg_sweeps  input  SWEEP_W  number of up+down sweeps; 0 = run until stop
cfg_dwell  input  DWELL_W  idle cycles at each turnaround; 0 = no dwell
cnt_count  input  CNT_W  counter value
cnt_tc  input  1  counter terminal count (max when counting up, 0 when counting down)
cnt_enable  output  1  to counter enable
cnt_mode  output  1  to counter mode; 0 = up, 1 = down
cnt_clear  output  1  registered pulse to the counter's reset pin
busy  output  1  high in CLEAR, UP, DWELL_TOP, DOWN, DWELL_BOT
done  output  1  one-cycle pulse when the programmed sweeps complete
sweep_idx  output  SWEEP_W  completed-sweep count; increments when DOWN reaches tc

Behaviour:
Reset (async, active-high):
- State goes to IDLE.
- All outputs go to 0: cnt_enable, cnt_mode, cnt_clear, busy, done, sweep_idx.
- Latched config is cleared.
- Reset mid-run abandons the run. Counter state is not restored.

State transitions:
- IDLE: on start, latch cfg_sweeps and cfg_dwell, clear sweep_idx, go to CLEAR. Config changes after start have no effect.
- CLEAR (1 cycle): cnt_clear=1. Next state is UP.
- UP: cnt_mode=0. When cnt_tc=1, go to DWELL_TOP if dwell is nonzero, otherwise go straight to DOWN.
- DWELL_TOP: lasts exactly dwell cycles, with cnt_mode already 1. Then go to DOWN.
- DOWN: cnt_mode=1. When cnt_tc=1, increment sweep_idx. Then:
  - if sweeps≠0 and sweep_idx+1==sweeps, go to DONE;
  - else if dwell≠0, go to DWELL_BOT;
  - else go to UP.
- DWELL_BOT: lasts dwell cycles, with cnt_mode=0. Then go to UP.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.

Enable and mode rules:
- cnt_enable is combinational: (state==UP or DOWN) and !cnt_tc and !stop. This guarantees the counter never wraps and halts in the same cycle stop is asserted.
- cnt_mode and cnt_clear are registered from the next-state decode.
- UP phase from 0 takes 2^CNT_W cycles: 2^CNT_W-1 counting cycles plus 1 tc cycle. DOWN phase is identical.

Boundary conditions:
- stop in any busy state: next state IDLE, done not pulsed, sweep_idx holds its value.
- stop and start together in IDLE: stop wins and start is ignored.
- start while busy: ignored.
- cfg_sweeps=0: sweep_idx wraps modulo 2^SWEEP_W and done never fires.
- In UP/DOWN, the tc transition uses cnt_tc only; cnt_count is not used.

Optional Feature:
UPDOWN_SWEEP_LIMIT_EN
- Defined:
  - adds input cfg_limit[CNT_W-1:0], latched at start;
  - the UP phase terminates when cnt_tc=1 or cnt_count==limit (either one is the turnaround event, and it also gates enable);
  - limit=0 makes the UP phase last 1 cycle.
- Undefined: no port; the UP turnaround is cnt_tc only.

Decomposition:
Shared package updown_pkg:
- state enum (IDLE, CLEAR, UP, DWELL_TOP, DOWN, DWELL_BOT, DONE);
- MODE_UP=1'b0, MODE_DOWN=1'b1;
- default width constants.

One sub-module, updown_dwell_timer: loadable down-counter that emits a single expiry pulse, reused for both dwell states. The FSM stays in the top level.

Test Plan:
- Reset mid-run: assert reset for 3 cycles at cycle 300 of a run -> all outputs 0 asynchronously, state IDLE; a later start runs normally.
- sweeps=2, dwell=0, start at t0 with a real counter attached:
  - cnt_clear at t0+1;
  - busy for 1025 cycles;
  - count peaks at 255 twice and bottoms at 0;
  - sweep_idx reaches 2;
  - done for 1 cycle at t0+1026;
  - cnt_count is never observed 255→0 while up or 0→255 while down.
- sweeps=1, dwell=5 -> count holds 255 for exactly 5 cycles with cnt_mode=1 and cnt_enable=0; total busy 1+256+5+256=518 cycles; no bottom dwell before DONE.
- stop asserted when count=100 in UP -> cnt_enable low that cycle, count frozen at 100, IDLE next cycle, no done pulse; start asserted during the run is ignored.
- sweeps=0, dwell=0 -> runs past 3 sweeps with no done; sweep_idx=3 after 3 bottoms; stop returns to IDLE.
- UPDOWN_SWEEP_LIMIT_EN defined, limit=10, sweeps=1 -> count 0..10..0, busy 1+11+11=23 cycles, done pulse.
